// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port memory bus arbiter: FSM state encodings,
// grant constants and the round-robin pick.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  localparam int unsigned CNT_W = 4;

  // On contention the port that did not own the bus last time wins.
  function automatic logic pick_grant(input logic req_a, input logic req_b,
                                      input logic last);
    logic g;
    if (req_a && req_b) begin
      g = ~last;
    end else if (req_a) begin
      g = GRANT_A;
    end else begin
      g = GRANT_B;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_path.sv
// Arbiter datapath: grant-selected request path towards memory and the
// grant-steered read-data/ack return path (unselected port reads zero).
module mem_bus_arbiter_path
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              grant,
  input  logic              cs,
  input  logic              done,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [DATA_W-1:0] hold,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  // Request path: select the owning port's address, data and write enable.
  always_comb begin
    mem_addr  = addr_a;
    mem_wdata = wdata_a;
    mem_we    = 1'b0;
    if (grant == GRANT_B) begin
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
      mem_we    = cs & we_b;
    end else begin
      mem_addr  = addr_a;
      mem_wdata = wdata_a;
      mem_we    = cs & we_a;
    end
  end

  // Return path: ack and held read data go only to the owner during DONE.
  always_comb begin
    ack_a   = 1'b0;
    ack_b   = 1'b0;
    rdata_a = {DATA_W{1'b0}};
    rdata_b = {DATA_W{1'b0}};
    if (done && (grant == GRANT_B)) begin
      ack_b   = 1'b1;
      rdata_b = hold;
    end else if (done) begin
      ack_a   = 1'b1;
      rdata_a = hold;
    end else begin
      ack_a   = 1'b0;
      ack_b   = 1'b0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for a shared memory bus with a fixed
// number of chip-select wait states and a one-cycle completion ack.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t        state_r;
  logic              grant_r;
  logic              last_r;
  logic              cs_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] hold_r;
  logic              done_s;

  // Arbitration FSM with wait-state counter and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      grant_r <= GRANT_B;
      last_r  <= GRANT_B;
      cs_r    <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      hold_r  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_a || req_b) begin
            grant_r <= pick_grant(req_a, req_b, last_r);
            cnt_r   <= CNT_LOAD;
            cs_r    <= 1'b1;
            state_r <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Last wait cycle: memory data is valid, latch it and release cs.
          if (cnt_r == {CNT_W{1'b0}}) begin
            hold_r  <= mem_rdata;
            cs_r    <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          last_r  <= grant_r;
          state_r <= ST_IDLE;
        end
        default: begin
          cs_r    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign done_s = (state_r == ST_DONE);
  assign mem_cs = cs_r;
  assign grant  = grant_r;

  mem_bus_arbiter_path #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_path (
    .grant     (grant_r),
    .cs        (cs_r),
    .done      (done_s),
    .we_a      (we_a),
    .addr_a    (addr_a),
    .wdata_a   (wdata_a),
    .we_b      (we_b),
    .addr_b    (addr_b),
    .wdata_b   (wdata_b),
    .hold      (hold_r),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .ack_a     (ack_a),
    .ack_b     (ack_b),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b)
  );

endmodule
